// File: rtl/noc_pipe_arbiter_pkg.sv
// rtl/noc_pipe_arbiter_pkg.sv - shared NOC beat types and arbiter state encoding
package noc_pipe_arbiter_pkg;

    localparam int NOC_LEN_WIDTH  = 16;
    localparam int NOC_DATA_WIDTH = 128;
    localparam int NOC_BEAT_WIDTH = NOC_LEN_WIDTH + NOC_DATA_WIDTH;

    typedef struct packed {
        logic [NOC_LEN_WIDTH-1:0]  len;
        logic [NOC_DATA_WIDTH-1:0] data;
    } noc_data_h_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/noc_rr_pick.sv
// rtl/noc_rr_pick.sv - combinational round-robin picker starting after the last grant
module noc_rr_pick #(
    parameter int NREQ = 2,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_eligible,
    input  logic [IDXW-1:0] i_last_grant,
    output logic            o_found,
    output logic [IDXW-1:0] o_pick
);

    localparam logic [IDXW:0] NREQ_W = (IDXW+1)'(NREQ);

    // Scan farthest-first so the nearest eligible index after last_grant wins.
    always_comb begin
        logic [IDXW:0] v_idx;
        o_found = 1'b0;
        o_pick  = '0;
        v_idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            v_idx = {1'b0, i_last_grant} + (IDXW+1)'(k);
            if (v_idx >= NREQ_W) begin
                v_idx = v_idx - NREQ_W;
            end
            if (i_eligible[v_idx[IDXW-1:0]]) begin
                o_found = 1'b1;
                o_pick  = v_idx[IDXW-1:0];
            end
        end
    end

endmodule

// File: rtl/noc_pipe_arbiter.sv
// rtl/noc_pipe_arbiter.sv - message-locked round-robin merge of NREQ NOC pipes into one
module noc_pipe_arbiter
    import noc_pipe_arbiter_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int DATA_WIDTH = NOC_DATA_WIDTH,
    parameter int LEN_WIDTH  = NOC_LEN_WIDTH
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    input  logic [NREQ*(LEN_WIDTH+DATA_WIDTH)-1:0]  in_first,
    input  logic [NREQ-1:0]                         in_first__RDY,
    input  logic [NREQ-1:0]                         in_deq__RDY,
    output logic [NREQ-1:0]                         in_deq__ENA,
    output logic                                    out_enq__ENA,
    output logic [LEN_WIDTH+DATA_WIDTH-1:0]         out_enq_v,
    input  logic                                    out_enq__RDY,
    output logic                                    busy,
    output logic [$clog2(NREQ)-1:0]                 grant_id
);

    localparam int BEAT_W = LEN_WIDTH + DATA_WIDTH;
    localparam int IDXW   = $clog2(NREQ);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic                   r_out_valid;
    logic [BEAT_W-1:0]      r_out_data;
    logic [LEN_WIDTH-1:0]   r_remaining;
    logic [IDXW-1:0]        r_last_grant;
    logic [IDXW-1:0]        r_grant_id;

    logic [NREQ-1:0]        w_eligible;
    logic                   w_slot_free;
    logic                   w_found;
    logic [IDXW-1:0]        w_pick;
    logic                   w_pop;
    logic [BEAT_W-1:0]      w_heads [NREQ];
    logic [BEAT_W-1:0]      w_pick_beat;
    logic [BEAT_W-1:0]      w_grant_beat;
    logic [BEAT_W-1:0]      w_pop_beat;
    logic [LEN_WIDTH-1:0]   w_pick_len;

    for (genvar g = 0; g < NREQ; g++) begin : g_heads
        assign w_heads[g] = in_first[g*BEAT_W +: BEAT_W];
    end

    assign w_eligible   = in_first__RDY & in_deq__RDY;
    assign w_slot_free  = !r_out_valid || out_enq__RDY;
    assign out_enq__ENA = r_out_valid && out_enq__RDY;
    assign out_enq_v    = r_out_data;
    assign busy         = (r_state == BURST);
    assign grant_id     = r_grant_id;

    assign w_pick_beat  = w_heads[w_pick];
    assign w_grant_beat = w_heads[r_grant_id];
    assign w_pick_len   = w_pick_beat[BEAT_W-1 -: LEN_WIDTH];
    assign w_pop_beat   = (r_state == IDLE) ? w_pick_beat : w_grant_beat;

    noc_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .i_eligible   (w_eligible),
        .i_last_grant (r_last_grant),
        .o_found      (w_found),
        .o_pick       (w_pick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found && w_slot_free) begin
                    w_pop = 1'b1;
                    if (w_pick_len != '0) begin
                        w_state_nxt = BURST;
                    end
                end
            end
            BURST: begin
                // Grant stays locked until the last continuation beat, even if that stalls.
                if (w_eligible[r_grant_id] && w_slot_free) begin
                    w_pop = 1'b1;
                    if (r_remaining == LEN_WIDTH'(1)) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_deq__ENA = '0;
        if (w_pop && !RST) begin
            in_deq__ENA[(r_state == IDLE) ? w_pick : r_grant_id] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_remaining  <= '0;
            r_last_grant <= IDXW'(NREQ-1);
            r_grant_id   <= IDXW'(NREQ-1);
        end else begin
            if (w_pop) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_pop_beat;
                if (r_state == IDLE) begin
                    r_grant_id <= w_pick;
                    if (w_pick_len == '0) begin
                        r_last_grant <= w_pick;
                    end else begin
                        r_remaining <= w_pick_len;
                    end
                end else begin
                    r_remaining <= r_remaining - LEN_WIDTH'(1);
                    if (r_remaining == LEN_WIDTH'(1)) begin
                        r_last_grant <= r_grant_id;
                    end
                end
            end else if (out_enq__ENA) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_noc_pipe_arbiter.sv
// tb/tb_noc_pipe_arbiter.sv - scoreboard bench for noc_pipe_arbiter with two requesters
module tb_noc_pipe_arbiter;
    import noc_pipe_arbiter_pkg::*;

    localparam int NREQ = 2;
    localparam int BW   = NOC_BEAT_WIDTH;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic [NREQ*BW-1:0]   in_first;
    logic [NREQ-1:0]      in_first__RDY;
    logic [NREQ-1:0]      in_deq__RDY;
    logic [NREQ-1:0]      in_deq__ENA;
    logic                 out_enq__ENA;
    logic [BW-1:0]        out_v;
    logic                 out_enq__RDY;
    logic                 busy;
    logic [0:0]           grant_id;

    logic [BW-1:0] q0[$];
    logic [BW-1:0] q1[$];
    logic [BW-1:0] exp_q[$];
    logic [1:0]    mask;
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 CLK = ~CLK;

    noc_pipe_arbiter #(
        .NREQ       (NREQ),
        .DATA_WIDTH (NOC_DATA_WIDTH),
        .LEN_WIDTH  (NOC_LEN_WIDTH)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .in_first      (in_first),
        .in_first__RDY (in_first__RDY),
        .in_deq__RDY   (in_deq__RDY),
        .in_deq__ENA   (in_deq__ENA),
        .out_enq__ENA  (out_enq__ENA),
        .out_enq_v     (out_v),
        .out_enq__RDY  (out_enq__RDY),
        .busy          (busy),
        .grant_id      (grant_id)
    );

    function automatic logic [BW-1:0] mk(input logic [15:0] l, input logic [127:0] d);
        noc_data_h_t b;
        b.len  = l;
        b.data = d;
        return b;
    endfunction

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive();
        in_first[BW-1:0]      = (q0.size() > 0) ? q0[0] : '0;
        in_first[2*BW-1:BW]   = (q1.size() > 0) ? q1[0] : '0;
        in_first__RDY[0]      = mask[0] && (q0.size() > 0);
        in_first__RDY[1]      = mask[1] && (q1.size() > 0);
        in_deq__RDY           = 2'b11;
    endtask

    task automatic push0(input logic [15:0] l, input logic [127:0] d);
        q0.push_back(mk(l, d));
    endtask
    task automatic push1(input logic [15:0] l, input logic [127:0] d);
        q1.push_back(mk(l, d));
    endtask
    task automatic expb(input logic [15:0] l, input logic [127:0] d);
        exp_q.push_back(mk(l, d));
    endtask

    task automatic pclk();
        @(posedge CLK);
        #1;
    endtask

    task automatic step_chk(input string nm, input logic [1:0] deq, input logic b);
        @(negedge CLK);
        check({nm, "_deq"}, in_deq__ENA, deq);
        check({nm, "_busy"}, busy, b);
    endtask

    // Requester FIFO model: a deq seen before the edge retires the head after it.
    initial begin
        logic [1:0] d;
        forever begin
            @(negedge CLK);
            d = in_deq__ENA;
            for (int i = 0; i < NREQ; i++) begin
                if (d[i]) check("deq_guard", {in_first__RDY[i], in_deq__RDY[i]}, 2'b11);
            end
            @(posedge CLK);
            #1;
            if (d[0] && q0.size() > 0) void'(q0.pop_front());
            if (d[1] && q1.size() > 0) void'(q1.pop_front());
            drive();
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (!RST && out_enq__ENA) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got %h expected none", out_v);
                end else begin
                    check("sb_beat", out_v, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        n_tests++;
        n_fail++;
        $display("FAIL timeout: got running expected finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        RST          = 1'b1;
        out_enq__RDY = 1'b1;
        mask         = 2'b11;
        push0(0, 128'h1); push0(0, 128'h2); push0(0, 128'h3);
        drive();
        repeat (2) pclk();
        @(negedge CLK);
        check("rst_busy", busy, 1'b0);
        check("rst_grant", grant_id, 1'b1);
        check("rst_out_ena", out_enq__ENA, 1'b0);
        check("rst_deq", in_deq__ENA, 2'b00);

        // single requester, three single-beat messages
        pclk();
        RST = 1'b0;
        expb(0, 128'h1); expb(0, 128'h2); expb(0, 128'h3);
        step_chk("t1_c0", 2'b01, 1'b0);
        check("t1_lat0", out_enq__ENA, 1'b0);
        step_chk("t1_c1", 2'b01, 1'b0);
        check("t1_lat1", out_enq__ENA, 1'b1);
        step_chk("t1_c2", 2'b01, 1'b0);
        step_chk("t1_c3", 2'b00, 1'b0);
        check("t1_grant", grant_id, 1'b0);

        // both eligible, single beats: alternate starting after last grant (req0)
        pclk();
        push0(0, 128'h10); push0(0, 128'h11);
        push1(0, 128'h20); push1(0, 128'h21); push1(0, 128'h22);
        drive();
        expb(0, 128'h20); expb(0, 128'h10); expb(0, 128'h21); expb(0, 128'h11); expb(0, 128'h22);
        step_chk("t2_c0", 2'b10, 1'b0);
        step_chk("t2_c1", 2'b01, 1'b0);
        step_chk("t2_c2", 2'b10, 1'b0);
        step_chk("t2_c3", 2'b01, 1'b0);
        step_chk("t2_c4", 2'b10, 1'b0);
        step_chk("t2_c5", 2'b00, 1'b0);

        // req0 len=2 burst locks out req1; continuation len field passes through
        pclk();
        push0(2, 128'h30); push0(16'hABCD, 128'h31); push0(0, 128'h32);
        push1(0, 128'h40);
        drive();
        expb(2, 128'h30); expb(16'hABCD, 128'h31); expb(0, 128'h32); expb(0, 128'h40);
        step_chk("t3_c0", 2'b01, 1'b0);
        step_chk("t3_c1", 2'b01, 1'b1);
        check("t3_grant1", grant_id, 1'b0);
        step_chk("t3_c2", 2'b01, 1'b1);
        check("t3_grant2", grant_id, 1'b0);
        step_chk("t3_c3", 2'b10, 1'b0);
        step_chk("t3_c4", 2'b00, 1'b0);

        // granted requester stalls mid-burst for 4 cycles
        pclk();
        push0(3, 128'h50); push0(0, 128'h51); push0(0, 128'h52); push0(0, 128'h53);
        push1(0, 128'h60);
        drive();
        expb(3, 128'h50); expb(0, 128'h51); expb(0, 128'h52); expb(0, 128'h53); expb(0, 128'h60);
        step_chk("t4_hdr", 2'b01, 1'b0);
        step_chk("t4_c1", 2'b01, 1'b1);
        pclk();
        mask = 2'b10;
        drive();
        for (int i = 0; i < 4; i++) begin
            step_chk("t4_stall", 2'b00, 1'b1);
            check("t4_stall_grant", grant_id, 1'b0);
        end
        pclk();
        mask = 2'b11;
        drive();
        step_chk("t4_c2", 2'b01, 1'b1);
        step_chk("t4_c3", 2'b01, 1'b1);
        step_chk("t4_r1", 2'b10, 1'b0);
        step_chk("t4_end", 2'b00, 1'b0);

        // downstream backpressure for 3 cycles
        pclk();
        push0(0, 128'h70); push0(0, 128'h71); push0(0, 128'h72);
        drive();
        expb(0, 128'h70); expb(0, 128'h71); expb(0, 128'h72);
        step_chk("t5_c0", 2'b01, 1'b0);
        pclk();
        out_enq__RDY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_chk("t5_hold", 2'b00, 1'b0);
            check("t5_hold_ena", out_enq__ENA, 1'b0);
            check("t5_hold_v", out_v, mk(0, 128'h70));
        end
        pclk();
        out_enq__RDY = 1'b1;
        step_chk("t5_r0", 2'b01, 1'b0);
        check("t5_r0_ena", out_enq__ENA, 1'b1);
        step_chk("t5_r1", 2'b01, 1'b0);
        step_chk("t5_r2", 2'b00, 1'b0);

        // reset during a len=5 burst discards it; req0 regains first priority
        pclk();
        push0(5, 128'h80);
        for (int i = 1; i <= 5; i++) push0(0, 128'h80 + 128'(i));
        drive();
        expb(5, 128'h80);
        step_chk("t6_hdr", 2'b01, 1'b0);
        step_chk("t6_c1", 2'b01, 1'b1);
        pclk();
        RST = 1'b1;
        step_chk("t6_in_rst", 2'b00, 1'b1);
        pclk();
        @(negedge CLK);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_ena", out_enq__ENA, 1'b0);
        check("t6_rst_grant", grant_id, 1'b1);
        check("t6_rst_deq", in_deq__ENA, 2'b00);
        pclk();
        RST = 1'b0;
        q0.delete();
        q1.delete();
        push0(0, 128'h90);
        push1(0, 128'hA0);
        drive();
        expb(0, 128'h90); expb(0, 128'hA0);
        step_chk("t6_g0", 2'b01, 1'b0);
        step_chk("t6_g1", 2'b10, 1'b0);
        step_chk("t6_end", 2'b00, 1'b0);

        repeat (3) pclk();
        check("sb_drain", 144'(exp_q.size()), 144'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
